// File: rtl/minisrc_run_ctrl.sv
// rtl/minisrc_run_ctrl.sv - run/clear/step controller for the Mini SRC datapath
module minisrc_run_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  step_i,
  input  logic                  step_mode_i,
  input  logic                  bp_en_i,
  input  logic [DATA_WIDTH-1:0] bp_addr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  instr_done_i,
  input  logic                  halt_instr_i,
  output logic                  run_o,
  output logic                  clr_o,
  output logic                  cpu_en_o,
  output logic [2:0]            halt_reason_o,
  output logic [CNT_WIDTH-1:0]  cycle_count_o,
  output logic [CNT_WIDTH-1:0]  instr_count_o
);

  typedef enum logic [1:0] {
    S_CLR    = 2'd0,
    S_IDLE   = 2'd1,
    S_RUN    = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  localparam logic [2:0] R_NONE = 3'd0;
  localparam logic [2:0] R_STOP = 3'd1;
  localparam logic [2:0] R_HALT = 3'd2;
  localparam logic [2:0] R_BP   = 3'd3;
  localparam logic [2:0] R_STEP = 3'd4;
  localparam logic [2:0] R_TMO  = 3'd5;

  // The clear counter counts down from CLR_CYCLES-1 to 0, so it only needs to hold CLR_CYCLES-1.
  localparam int                   CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0]     CLR_LOAD = CLR_W'(CLR_CYCLES - 1);
  localparam logic [CLR_W-1:0]     CLR_ONE  = CLR_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  // Timeout fires in the cycle whose pre-increment count is TIMEOUT-1, i.e. the TIMEOUT-th enabled cycle.
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic                 TMO_ON   = (TIMEOUT != 0);

  state_e               state_q, state_d;
  logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic                 oneshot_q, oneshot_d;
  logic [2:0]           reason_q, reason_d;
  logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] ins_q, ins_d;
  logic [CNT_WIDTH-1:0] tmo_q, tmo_d;

  logic timeout_hit;
  logic bp_hit;
  logic halt_now;
  logic [2:0] halt_code;

  assign timeout_hit = TMO_ON && (tmo_q == TMO_LAST);
  assign bp_hit      = bp_en_i && (pc_i == bp_addr_i);

  // Halt priority encoder: timeout can cut an instruction short, everything else waits for instr_done.
  always_comb begin
    halt_now  = 1'b0;
    halt_code = R_NONE;
    if (timeout_hit) begin
      halt_now  = 1'b1;
      halt_code = R_TMO;
    end else if (instr_done_i && halt_instr_i) begin
      halt_now  = 1'b1;
      halt_code = R_HALT;
    end else if (instr_done_i && bp_hit) begin
      halt_now  = 1'b1;
      halt_code = R_BP;
    end else if (instr_done_i && stop_i) begin
      halt_now  = 1'b1;
      halt_code = R_STOP;
    end else if (instr_done_i && oneshot_q) begin
      halt_now  = 1'b1;
      halt_code = R_STEP;
    end
  end

  // Next-state and counter update logic; IDLE and HALTED share the launch rules.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    oneshot_d = oneshot_q;
    reason_d  = reason_q;
    cyc_d     = cyc_q;
    ins_d     = ins_q;
    tmo_d     = tmo_q;
    case (state_q)
      S_CLR: begin
        if (clr_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q - CLR_ONE;
        end
      end
      S_IDLE, S_HALTED: begin
        // step outranks start, and a held stop masks start but not step.
        if (step_i || (start_i && !stop_i)) begin
          state_d   = S_RUN;
          oneshot_d = step_i | step_mode_i;
          reason_d  = R_NONE;
          tmo_d     = '0;
        end
      end
      S_RUN: begin
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + CNT_ONE;
        tmo_d = (&tmo_q) ? tmo_q : tmo_q + CNT_ONE;
        if (instr_done_i) begin
          ins_d = (&ins_q) ? ins_q : ins_q + CNT_ONE;
        end
        if (halt_now) begin
          state_d   = S_HALTED;
          oneshot_d = 1'b0;
          reason_d  = halt_code;
        end
      end
      default: begin
        state_d = S_CLR;
      end
    endcase
  end

  // State register; reset reloads the clear sequence from any state, even mid-instruction.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_CLR;
      clr_cnt_q <= CLR_LOAD;
      oneshot_q <= 1'b0;
      reason_q  <= R_NONE;
      cyc_q     <= '0;
      ins_q     <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      oneshot_q <= oneshot_d;
      reason_q  <= reason_d;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
      tmo_q     <= tmo_d;
    end
  end

  assign run_o         = (state_q == S_RUN);
  assign cpu_en_o      = (state_q == S_RUN);
  assign clr_o         = (state_q == S_CLR);
  assign halt_reason_o = reason_q;
  assign cycle_count_o = cyc_q;
  assign instr_count_o = ins_q;

endmodule

// File: tb/tb_minisrc_run_ctrl.sv
// tb/tb_minisrc_run_ctrl.sv - directed bench for minisrc_run_ctrl
module tb_minisrc_run_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        step = 1'b0;
  logic        step_mode = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;
  logic [31:0] pc = 32'h0;
  logic        instr_done = 1'b0;
  logic        halt_instr = 1'b0;

  logic        run, clr, cpu_en;
  logic [2:0]  halt_reason;
  logic [31:0] cycle_count, instr_count;

  logic        t_run, t_clr, t_cpu_en;
  logic [2:0]  t_halt_reason;
  logic [31:0] t_cycle_count, t_instr_count;

  int vecs = 0;
  int errs = 0;

  minisrc_run_ctrl u_dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .stop_i(stop), .step_i(step),
    .step_mode_i(step_mode), .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc),
    .instr_done_i(instr_done), .halt_instr_i(halt_instr),
    .run_o(run), .clr_o(clr), .cpu_en_o(cpu_en), .halt_reason_o(halt_reason),
    .cycle_count_o(cycle_count), .instr_count_o(instr_count)
  );

  minisrc_run_ctrl #(.TIMEOUT(5)) u_tmo (
    .clk_i(clk), .reset_i(reset), .start_i(start), .stop_i(stop), .step_i(step),
    .step_mode_i(step_mode), .bp_en_i(bp_en), .bp_addr_i(bp_addr), .pc_i(pc),
    .instr_done_i(instr_done), .halt_instr_i(halt_instr),
    .run_o(t_run), .clr_o(t_clr), .cpu_en_o(t_cpu_en), .halt_reason_o(t_halt_reason),
    .cycle_count_o(t_cycle_count), .instr_count_o(t_instr_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    start = 0; stop = 0; step = 0; step_mode = 0; bp_en = 0;
    instr_done = 0; halt_instr = 0;
    reset = 1; tick;
    reset = 0; tick; tick;
  endtask

  task automatic test_reset;
    int clr_cyc;
    reset = 1; tick;
    vecs++; if (clr !== 1'b1) begin errs++; $display("FAIL reset_clr: got %0b exp 1", clr); end
    vecs++; if (run !== 1'b0 || cpu_en !== 1'b0) begin errs++; $display("FAIL reset_run: got run=%0b en=%0b exp 0/0", run, cpu_en); end
    vecs++; if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin errs++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", cycle_count, instr_count); end
    vecs++; if (halt_reason !== 3'd0) begin errs++; $display("FAIL reset_reason: got %0d exp 0", halt_reason); end
    reset = 0; tick;
    vecs++; if (clr !== 1'b1) begin errs++; $display("FAIL clr_cycle2: got %0b exp 1", clr); end
    tick;
    vecs++; if (clr !== 1'b0 || run !== 1'b0) begin errs++; $display("FAIL idle_after_clr: got clr=%0b run=%0b exp 0/0", clr, run); end
    reset = 1; tick; tick; tick;
    reset = 0;
    clr_cyc = 0;
    for (int i = 0; i < 10 && clr; i++) begin clr_cyc++; tick; end
    vecs++; if (clr_cyc !== 2) begin errs++; $display("FAIL held_reset_clr_len: got %0d exp 2", clr_cyc); end
    instr_done = 1; halt_instr = 1; tick;
    instr_done = 0; halt_instr = 0; tick;
    vecs++; if (instr_count !== 32'd0 || halt_reason !== 3'd0 || run !== 1'b0) begin errs++; $display("FAIL idle_ignores_done: got ic=%0d hr=%0d run=%0b exp 0/0/0", instr_count, halt_reason, run); end
  endtask

  task automatic test_free_run;
    int run_cyc;
    do_reset;
    start = 1; tick; start = 0;
    run_cyc = 0;
    for (int c = 1; c <= 20 && run; c++) begin
      instr_done = (c % 3 == 0);
      halt_instr = (c == 12);
      run_cyc++;
      tick;
    end
    instr_done = 0; halt_instr = 0;
    vecs++; if (run_cyc !== 12) begin errs++; $display("FAIL free_run_len: got %0d exp 12", run_cyc); end
    vecs++; if (halt_reason !== 3'd2) begin errs++; $display("FAIL free_run_reason: got %0d exp 2", halt_reason); end
    vecs++; if (instr_count !== 32'd4 || cycle_count !== 32'd12) begin errs++; $display("FAIL free_run_counts: got ic=%0d cc=%0d exp 4/12", instr_count, cycle_count); end
  endtask

  task automatic test_breakpoint;
    int run_cyc;
    int n;
    do_reset;
    bp_en = 1; bp_addr = 32'h10; pc = 32'h08;
    start = 1; tick; start = 0;
    run_cyc = 0; n = 0;
    for (int c = 1; c <= 20 && run; c++) begin
      instr_done = (c % 2 == 0);
      if (instr_done) n++;
      pc = 32'h08 + 32'(4 * n);
      run_cyc++;
      tick;
    end
    instr_done = 0;
    vecs++; if (run_cyc !== 4 || halt_reason !== 3'd3) begin errs++; $display("FAIL bp_halt: got len=%0d hr=%0d exp 4/3", run_cyc, halt_reason); end
    vecs++; if (instr_count !== 32'd2) begin errs++; $display("FAIL bp_instr_count: got %0d exp 2", instr_count); end
    start = 1; tick; start = 0;
    vecs++; if (run !== 1'b1 || halt_reason !== 3'd0) begin errs++; $display("FAIL bp_resume: got run=%0b hr=%0d exp 1/0", run, halt_reason); end
    pc = 32'h10; tick;
    instr_done = 1; pc = 32'h14; tick;
    instr_done = 0;
    vecs++; if (run !== 1'b1 || instr_count !== 32'd3 || halt_reason !== 3'd0) begin errs++; $display("FAIL bp_no_retrigger: got run=%0b ic=%0d hr=%0d exp 1/3/0", run, instr_count, halt_reason); end
    bp_en = 0;
  endtask

  task automatic test_single_step;
    int burst;
    do_reset;
    step_mode = 1;
    for (int b = 0; b < 3; b++) begin
      vecs++; if (run !== 1'b0) begin errs++; $display("FAIL step_idle_%0d: got run=%0b exp 0", b, run); end
      start = 1; tick; start = 0;
      burst = 0;
      for (int c = 1; c <= 10 && cpu_en; c++) begin
        instr_done = (c == 4);
        burst++;
        tick;
      end
      instr_done = 0;
      vecs++; if (burst !== 4 || halt_reason !== 3'd4) begin errs++; $display("FAIL step_burst_%0d: got len=%0d hr=%0d exp 4/4", b, burst, halt_reason); end
    end
    vecs++; if (instr_count !== 32'd3 || cycle_count !== 32'd12) begin errs++; $display("FAIL step_counts: got ic=%0d cc=%0d exp 3/12", instr_count, cycle_count); end
    step_mode = 0;
    step = 1; start = 1; tick; step = 0; start = 0;
    burst = 0;
    for (int c = 1; c <= 10 && cpu_en; c++) begin
      instr_done = (c == 2);
      burst++;
      tick;
    end
    instr_done = 0;
    vecs++; if (burst !== 2 || halt_reason !== 3'd4 || instr_count !== 32'd4) begin errs++; $display("FAIL step_beats_start: got len=%0d hr=%0d ic=%0d exp 2/4/4", burst, halt_reason, instr_count); end
  endtask

  task automatic test_stop_priority;
    int run_cyc;
    do_reset;
    start = 1; tick; start = 0;
    run_cyc = 0;
    for (int c = 1; c <= 20 && run; c++) begin
      instr_done = (c % 3 == 0);
      stop = (c >= 5);
      run_cyc++;
      tick;
    end
    instr_done = 0;
    vecs++; if (run_cyc !== 6 || halt_reason !== 3'd1 || instr_count !== 32'd2) begin errs++; $display("FAIL stop_boundary: got len=%0d hr=%0d ic=%0d exp 6/1/2", run_cyc, halt_reason, instr_count); end
    start = 1; tick; start = 0;
    vecs++; if (run !== 1'b0 || halt_reason !== 3'd1) begin errs++; $display("FAIL start_masked_by_stop: got run=%0b hr=%0d exp 0/1", run, halt_reason); end
    stop = 0;
    start = 1; tick; start = 0;
    run_cyc = 0;
    for (int c = 1; c <= 20 && run; c++) begin
      instr_done = (c % 3 == 0);
      halt_instr = (c == 3);
      stop = (c == 3);
      run_cyc++;
      tick;
    end
    instr_done = 0; halt_instr = 0; stop = 0;
    vecs++; if (run_cyc !== 3 || halt_reason !== 3'd2) begin errs++; $display("FAIL halt_over_stop: got len=%0d hr=%0d exp 3/2", run_cyc, halt_reason); end
    vecs++; if (instr_count !== 32'd3 || cycle_count !== 32'd9) begin errs++; $display("FAIL stop_counts: got ic=%0d cc=%0d exp 3/9", instr_count, cycle_count); end
  endtask

  task automatic test_timeout_reset;
    int en_cyc;
    do_reset;
    start = 1; tick; start = 0;
    en_cyc = 0;
    for (int c = 1; c <= 20 && t_cpu_en; c++) begin en_cyc++; tick; end
    vecs++; if (en_cyc !== 5 || t_halt_reason !== 3'd5) begin errs++; $display("FAIL timeout_halt: got len=%0d hr=%0d exp 5/5", en_cyc, t_halt_reason); end
    vecs++; if (t_cycle_count !== 32'd5 || t_instr_count !== 32'd0) begin errs++; $display("FAIL timeout_counts: got cc=%0d ic=%0d exp 5/0", t_cycle_count, t_instr_count); end
    start = 1; tick; start = 0;
    tick; tick;
    vecs++; if (t_run !== 1'b1 || t_cycle_count !== 32'd7 || t_halt_reason !== 3'd0) begin errs++; $display("FAIL restart_cycle3: got run=%0b cc=%0d hr=%0d exp 1/7/0", t_run, t_cycle_count, t_halt_reason); end
    reset = 1; tick; reset = 0;
    vecs++; if (t_clr !== 1'b1 || t_run !== 1'b0 || t_cpu_en !== 1'b0) begin errs++; $display("FAIL midrun_reset_state: got clr=%0b run=%0b en=%0b exp 1/0/0", t_clr, t_run, t_cpu_en); end
    vecs++; if (t_cycle_count !== 32'd0 || t_instr_count !== 32'd0 || t_halt_reason !== 3'd0) begin errs++; $display("FAIL midrun_reset_counts: got cc=%0d ic=%0d hr=%0d exp 0/0/0", t_cycle_count, t_instr_count, t_halt_reason); end
  endtask

  initial begin
    test_reset;
    test_free_run;
    test_breakpoint;
    test_single_step;
    test_stop_priority;
    test_timeout_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/minisrc_run_ctrl.md
# minisrc_run_ctrl

Parametrised run controller for the Mini SRC datapath. It replaces the bare `run`/`clr`/`stop` handling with a Moore state machine that has:
- a timed clear sequence,
- free-run and single-step modes,
- a PC breakpoint and a cycle-budget timeout,
- saturating cycle and instruction counters.

It sits between the system inputs (`start`, `stop`, `step`) and the control unit. It drives the datapath clock-enable and the `run`/`clr` status lines.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of the PC and the breakpoint address.
- `CNT_WIDTH`, 32, width of `cycle_count`, `instr_count` and the timeout counter.
- `CLR_CYCLES`, 2, number of cycles `clr` is held after reset; must be ≥1.
- `TIMEOUT`, 0, maximum enabled cycles per start; 0 disables the timeout.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse; begins free-run from IDLE or HALTED.
- `stop` in 1: level; requests a halt at the next instruction boundary.
- `step` in 1: one-cycle pulse; executes exactly one instruction from IDLE or HALTED.
- `step_mode` in 1: when high, every start behaves as a step.
- `bp_en` in 1: enables the breakpoint.
- `bp_addr` in DATA_WIDTH: breakpoint PC value.
- `pc` in DATA_WIDTH: `PC_Data` from the datapath.
- `instr_done` in 1: pulsed by the control unit in the last T-step of each instruction; only valid while `cpu_en`=1.
- `halt_instr` in 1: high with `instr_done` when a halt instruction completes.
- `run` out 1: high while executing.
- `clr` out 1: datapath clear.
- `cpu_en` out 1: datapath/control-unit clock enable.
- `halt_reason` out 3: why the controller halted (codes below).
- `cycle_count` out CNT_WIDTH: total enabled cycles.
- `instr_count` out CNT_WIDTH: completed instructions.

## Operation
States: CLR, IDLE, RUN, HALTED. Outputs are decoded from registered state (Moore):
- `run` = `cpu_en` = (state==RUN).
- `clr` = (state==CLR).

Reset (any state, any cycle, including mid-instruction):
- Next state CLR.
- CLR counter loaded, one-shot step flag cleared.
- `halt_reason`=0, `cycle_count`=0, `instr_count`=0, timeout counter=0.
- Resulting outputs: `run`=0, `cpu_en`=0, `clr`=1.

CLR: holds `clr`=1 for exactly CLR_CYCLES cycles, then goes to IDLE.

IDLE and HALTED, launch rules:
- `step`, or `start` with `step_mode`=1: go to RUN with the one-shot flag set.
- `start` with `step_mode`=0: go to RUN, flag clear.
- `step` and `start` in the same cycle: `step` wins.
- `start` is ignored while `stop`=1.
- Every launch clears `halt_reason` to 0 and the timeout counter to 0.
- IDLE and HALTED are otherwise identical; HALTED holds `halt_reason` until the next launch.

RUN, every cycle:
- `cycle_count` and the timeout counter increment, saturating at all-ones.
- On `instr_done`, `instr_count` increments (saturating).

Halt evaluation in RUN (next state HALTED). Highest priority first; one code is latched:
- 5 timeout: TIMEOUT≠0 and the timeout counter == TIMEOUT−1 this cycle. This applies in any RUN cycle, even mid-instruction.
- 2 halt instruction: `instr_done` & `halt_instr`.
- 3 breakpoint: `instr_done` & `bp_en` & (`pc`==`bp_addr`). `pc` is compared in the `instr_done` cycle, so the match is on the already-updated PC. Resuming from a breakpoint does not re-trigger until the next completed instruction.
- 1 stop: `instr_done` & `stop`.
- 4 step complete: `instr_done` & one-shot flag set.

Other rules:
- Code 0 means no halt has occurred since the last launch or reset.
- `instr_done` or `halt_instr` outside RUN is ignored; counters are unchanged.

## Timing
- `start`/`step` sampled at edge N: `run`=`cpu_en`=1 from edge N+1.
- The halting cycle (`instr_done` or timeout) is the last cycle with `cpu_en`=1. At the following edge, `run`=0 and `halt_reason` is valid.
- A single-stepped instruction of K T-steps gives exactly K cycles of `cpu_en` and +1 `instr_count`.
- Counters update at the same edge that ends the cycle they count.
- `clr` is high for CLR_CYCLES cycles starting at the edge after `reset` is sampled high.
- `reset` held high for several cycles keeps the controller in CLR with its counter reloaded. The clear sequence starts when `reset` drops.

## Test plan
- Reset, CLR_CYCLES=2: `reset` high for 1 cycle → `clr`=1 for exactly 2 cycles, then IDLE. `run`=0, `cycle_count`=0, `instr_count`=0, `halt_reason`=0.
- Free run with halt: `start`; 3-cycle instructions; `halt_instr` with the 4th `instr_done` → `run` high for 12 cycles, `halt_reason`=2, `instr_count`=4, `cycle_count`=12.
- Breakpoint: `bp_en`=1, `bp_addr`=0x10; PC reaches 0x10 at the 2nd `instr_done` → HALTED, reason 3. A new `start` → 3rd instruction completes with `pc`=0x14 and does not re-trigger.
- Single step: `step_mode`=1, 3 `start` pulses, 4-cycle instructions → 3 separate 4-cycle `cpu_en` bursts, each ending with reason 4. `instr_count`=3.
- Stop and priority: `stop` raised mid-instruction → halt only at `instr_done`, reason 1. `stop` and `halt_instr` at the same `instr_done` → reason 2.
- Timeout and reset: TIMEOUT=5, instruction never completes → `cpu_en` high exactly 5 cycles, reason 5. Then restart and assert `reset` on cycle 3 of RUN → CLR next edge, all counters 0.
